// File: rtl/common_pkg.sv
// Shared parameters and types for the systolic array datapath and its write-back stage.
package common_pkg;

    localparam int unsigned SYS_ARRAY_SIZE = 4;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned ROW_BITS       = SYS_ARRAY_SIZE * DATA_WIDTH;
    localparam int unsigned ROW_BYTES      = ROW_BITS / 8;
    localparam int unsigned ROW_IDX_W      = $clog2(SYS_ARRAY_SIZE);
    localparam int unsigned CNT_W          = $clog2(SYS_ARRAY_SIZE + 1);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [CNT_W-1:0]      countn_t;

    // Element j of a row sits at bits [j*DATA_WIDTH +: DATA_WIDTH].
    typedef data_t [SYS_ARRAY_SIZE-1:0] row_t;
    typedef row_t  [SYS_ARRAY_SIZE-1:0] tile_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_ARMED,
        WB_WRITE,
        WB_DONE
    } wb_state_t;

    // Row stride step; wraps modulo 2^ADDR_WIDTH.
    function automatic addr_t next_row_addr(input addr_t addr);
        return addr + ADDR_WIDTH'(ROW_BYTES);
    endfunction

endpackage

// File: rtl/result_snapshot.sv
// N x N result register file: captures the whole array output on one enable,
// then serves one row at a time through a combinational read port.
module result_snapshot
    import common_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cap_i,
    input  tile_t                c_i,
    input  logic [ROW_IDX_W-1:0] rd_row_i,
    output row_t                 rd_data_c
);

    tile_t mem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (cap_i) begin
            mem_q <= c_i;
        end
    end

    assign rd_data_c = mem_q[rd_row_i];

endmodule

// File: rtl/wdata_handler.sv
// Write-back stage: snapshots the systolic array result on last_i and streams it
// to memory C one row per cycle, clearing the accumulators on the first row.
module wdata_handler
    import common_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_c_i,
    input  logic                  last_i,
    input  tile_t                 c_i,
    output logic                  acc_clr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  en_c_o,
    output logic                  we_c_o,
    output logic [ADDR_WIDTH-1:0] addr_c_o,
    output logic [ROW_BITS-1:0]   wdata_c_o
);

    wb_state_t             state_q, state_d;
    countn_t               row_q, row_d;
    addr_t                 addr_q, addr_d;
    logic                  capture;
    logic [ROW_IDX_W-1:0]  rd_row;
    row_t                  snap_row;
    row_t                  row_nxt;

    logic                  acc_clr_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  en_d;
    addr_t                 addr_out_d;
    logic [ROW_BITS-1:0]   wdata_d;

    assign rd_row = ROW_IDX_W'(row_d);

    result_snapshot u_snapshot (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cap_i     (capture),
        .c_i       (c_i),
        .rd_row_i  (rd_row),
        .rd_data_c (snap_row)
    );

    // State register and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WB_IDLE;
            row_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
        end
    end

    // Next state, counter/address update, and next-cycle output values.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        addr_d  = addr_q;
        capture = 1'b0;

        unique case (state_q)
            WB_IDLE: begin
                if (start_i) begin
                    addr_d  = addr_c_i;
                    state_d = WB_ARMED;
                end
            end
            WB_ARMED: begin
                if (last_i) begin
                    capture = 1'b1;
                    row_d   = '0;
                    state_d = WB_WRITE;
                end
            end
            WB_WRITE: begin
                row_d  = row_q + countn_t'(1);
                addr_d = next_row_addr(addr_q);
                if (row_q == countn_t'(SYS_ARRAY_SIZE - 1)) begin
                    state_d = WB_DONE;
                end
            end
            WB_DONE: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase

        // Row 0 is being captured this very edge, so take it straight from the array.
        row_nxt = capture ? c_i[0] : snap_row;

        en_d       = (state_d == WB_WRITE);
        busy_d     = (state_d != WB_IDLE);
        done_d     = (state_d == WB_DONE);
        acc_clr_d  = en_d && (row_d == '0);
        addr_out_d = en_d ? addr_d : '0;
        wdata_d    = en_d ? ROW_BITS'(row_nxt) : '0;
    end

    // Outputs are registered copies of the values decoded for the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_clr_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            en_c_o    <= 1'b0;
            addr_c_o  <= '0;
            wdata_c_o <= '0;
        end else begin
            acc_clr_o <= acc_clr_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
            en_c_o    <= en_d;
            addr_c_o  <= addr_out_d;
            wdata_c_o <= wdata_d;
        end
    end

    assign we_c_o = en_c_o;

endmodule

// File: tb/tb_wdata_handler.sv
// Self-checking bench for wdata_handler: table of tiles plus reset and stray-event sequences.
module tb_wdata_handler;
    import common_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] addr_c_i;
    logic                  last_i;
    tile_t                 c_i;
    logic                  acc_clr_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  en_c_o;
    logic                  we_c_o;
    logic [ADDR_WIDTH-1:0] addr_c_o;
    logic [ROW_BITS-1:0]   wdata_c_o;

    wdata_handler dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .addr_c_i  (addr_c_i),
        .last_i    (last_i),
        .c_i       (c_i),
        .acc_clr_o (acc_clr_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .en_c_o    (en_c_o),
        .we_c_o    (we_c_o),
        .addr_c_o  (addr_c_o),
        .wdata_c_o (wdata_c_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        addr_t                                  base;
        data_t                                  seed;
        logic [SYS_ARRAY_SIZE-1:0][ADDR_WIDTH-1:0] exp_addr;
        logic                                   glitch;
        logic                                   stray;
    } vec_t;

    typedef struct packed {
        addr_t addr;
        row_t  data;
        logic  clr;
    } wr_t;

    localparam int NVEC = 5;

    vec_t vecs [NVEC];
    wr_t  sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [ROW_BITS-1:0] act,
                       input logic [ROW_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tile_t make_tile(input data_t seed);
        tile_t t;
        for (int i = 0; i < SYS_ARRAY_SIZE; i++)
            for (int j = 0; j < SYS_ARRAY_SIZE; j++)
                t[i][j] = seed + data_t'(16 * i + j);
        return t;
    endfunction

    task automatic set_vec(input int idx, input addr_t base, input data_t seed,
                           input addr_t a0, input addr_t a1, input addr_t a2, input addr_t a3,
                           input logic glitch, input logic stray);
        vecs[idx].base     = base;
        vecs[idx].seed     = seed;
        vecs[idx].exp_addr = {a3, a2, a1, a0};
        vecs[idx].glitch   = glitch;
        vecs[idx].stray    = stray;
    endtask

    task automatic push_rows(input tile_t t, input logic [SYS_ARRAY_SIZE-1:0][ADDR_WIDTH-1:0] a);
        for (int i = 0; i < SYS_ARRAY_SIZE; i++) begin
            wr_t w;
            w.addr = a[i];
            w.data = t[i];
            w.clr  = (i == 0);
            sb_q.push_back(w);
        end
    endtask

    // Write monitor: every memory write must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (en_c_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h expected no write at %0t",
                             addr_c_o, $time);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("wr_addr", ROW_BITS'(addr_c_o), ROW_BITS'(e.addr));
                    chk("wr_data", wdata_c_o, ROW_BITS'(e.data));
                    chk("wr_acc_clr", ROW_BITS'(acc_clr_o), ROW_BITS'(e.clr));
                    chk("wr_we", ROW_BITS'(we_c_o), ROW_BITS'(1'b1));
                end
            end else begin
                chk("clr_no_write", ROW_BITS'(acc_clr_o), ROW_BITS'(1'b0));
            end
        end
    end

    // Entered and left on a falling edge; starts the tile immediately.
    task automatic run_tile(input vec_t v);
        tile_t t;
        t        = make_tile(v.seed);
        start_i  = 1'b1;
        addr_c_i = v.base;
        @(negedge clk_i);
        start_i  = 1'b0;
        addr_c_i = '0;
        chk("busy_armed", ROW_BITS'(busy_o), ROW_BITS'(1'b1));
        chk("no_write_armed", ROW_BITS'(en_c_o), ROW_BITS'(1'b0));
        c_i    = t;
        last_i = 1'b1;
        push_rows(t, v.exp_addr);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                last_i = 1'b0;
                if (v.glitch) c_i = '1;
            end
            if (k == 2 && v.stray) begin
                start_i  = 1'b1;
                addr_c_i = 16'h5550;
            end
            if (k == 3) begin
                start_i  = 1'b0;
                addr_c_i = '0;
            end
            if (k == 4) chk("done_early", ROW_BITS'(done_o), ROW_BITS'(1'b0));
            if (k == 5) begin
                chk("done_pulse", ROW_BITS'(done_o), ROW_BITS'(1'b1));
                chk("no_write_done", ROW_BITS'(en_c_o), ROW_BITS'(1'b0));
                chk("busy_done", ROW_BITS'(busy_o), ROW_BITS'(1'b1));
            end
            if (k == 6) begin
                chk("busy_fall", ROW_BITS'(busy_o), ROW_BITS'(1'b0));
                chk("done_single", ROW_BITS'(done_o), ROW_BITS'(1'b0));
                chk("rows_written", ROW_BITS'(sb_q.size()), ROW_BITS'(0));
            end
        end
        if (v.stray) begin
            @(negedge clk_i);
            chk("stray_start_dropped", ROW_BITS'(busy_o), ROW_BITS'(1'b0));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_acc_clr"}, ROW_BITS'(acc_clr_o), '0);
        chk({tag, "_busy"},    ROW_BITS'(busy_o), '0);
        chk({tag, "_done"},    ROW_BITS'(done_o), '0);
        chk({tag, "_en"},      ROW_BITS'(en_c_o), '0);
        chk({tag, "_we"},      ROW_BITS'(we_c_o), '0);
        chk({tag, "_addr"},    ROW_BITS'(addr_c_o), '0);
        chk({tag, "_wdata"},   wdata_c_o, '0);
    endtask

    initial begin
        set_vec(0, 16'h0100, 32'h0000_0000, 16'h0100, 16'h0110, 16'h0120, 16'h0130, 1'b0, 1'b0);
        set_vec(1, 16'h2000, 32'h0000_1000, 16'h2000, 16'h2010, 16'h2020, 16'h2030, 1'b1, 1'b0);
        set_vec(2, 16'hFFE0, 32'hABCD_0000, 16'hFFE0, 16'hFFF0, 16'h0000, 16'h0010, 1'b0, 1'b0);
        set_vec(3, 16'h0040, 32'h7FFF_FFF8, 16'h0040, 16'h0050, 16'h0060, 16'h0070, 1'b0, 1'b1);
        set_vec(4, 16'hFFF0, 32'hFFFF_FFF0, 16'hFFF0, 16'h0000, 16'h0010, 16'h0020, 1'b1, 1'b0);

        rst_i    = 1'b1;
        start_i  = 1'b0;
        addr_c_i = '0;
        last_i   = 1'b0;
        c_i      = '0;
        repeat (2) @(negedge clk_i);
        chk_outputs_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Consecutive tiles: each start lands on the cycle busy_o has just fallen.
        for (int i = 0; i < NVEC; i++) run_tile(vecs[i]);

        // Stray last_i in IDLE: must neither write nor leave IDLE.
        c_i    = make_tile(32'h0000_0900);
        last_i = 1'b1;
        @(negedge clk_i);
        last_i = 1'b0;
        chk("stray_last_busy", ROW_BITS'(busy_o), ROW_BITS'(1'b0));
        @(negedge clk_i);
        chk("stray_last_busy2", ROW_BITS'(busy_o), ROW_BITS'(1'b0));

        // Reset once row 1 has been written.
        start_i  = 1'b1;
        addr_c_i = 16'h0300;
        @(negedge clk_i);
        start_i  = 1'b0;
        c_i      = make_tile(32'h0000_0500);
        last_i   = 1'b1;
        push_rows(make_tile(32'h0000_0500), {16'h0330, 16'h0320, 16'h0310, 16'h0300});
        @(negedge clk_i);
        last_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1 chk_outputs_zero("mid_reset");
        chk("rows_before_reset", ROW_BITS'(sb_q.size()), ROW_BITS'(2));
        sb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            chk("after_reset_idle", ROW_BITS'(busy_o), ROW_BITS'(1'b0));
        end
        run_tile(vecs[0]);
        run_tile(vecs[2]);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", ROW_BITS'(sb_q.size()), ROW_BITS'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
